// File: rtl/rr_merge2to1_if.sv
// rr_merge2to1_if: handshake bundle for the two branch inputs and the merged output.
interface rr_merge2to1_if #(parameter int WIDTH = 8);
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ready;
    modport master (
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, out_valid, out_data, out_src
    );
    modport slave (
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/rr_merge2to1.sv
// rr_merge2to1: round-robin merge of two valid/ready streams into one registered, source-tagged stream.
module rr_merge2to1 #(parameter int WIDTH = 8) (
    input  logic               clk,
    input  logic               rst_n,
    rr_merge2to1_if.slave      bus
);
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_src_q, out_src_d;
    logic             last_src_q, last_src_d;
    logic             can_load, grant_a, grant_b, accept;
    // on a tie the source that did not win last time gets the grant
    always_comb begin
        can_load    = !out_valid_q || bus.out_ready;
        grant_a     = bus.a_valid && (!bus.b_valid || last_src_q);
        grant_b     = bus.b_valid && (!bus.a_valid || !last_src_q);
        accept      = rst_n && can_load && (grant_a || grant_b);
        out_valid_d = accept ? 1'b1 : (bus.out_ready ? 1'b0 : out_valid_q);
        out_data_d  = accept ? (grant_b ? bus.b_data : bus.a_data) : out_data_q;
        out_src_d   = accept ? grant_b : out_src_q;
        last_src_d  = accept ? grant_b : last_src_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
            last_src_q  <= 1'b1;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            last_src_q  <= last_src_d;
        end
    end
    assign bus.a_ready   = rst_n && can_load && grant_a;
    assign bus.b_ready   = rst_n && can_load && grant_b;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_rr_merge2to1.sv
// tb_rr_merge2to1: directed checks of arbitration, latency, backpressure and async reset.
module tb_rr_merge2to1;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   passed = 0;
    rr_merge2to1_if #(.WIDTH(8)) bus ();
    rr_merge2to1 #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask
    task automatic drv(input logic av, input logic [7:0] ad, input logic bv, input logic [7:0] bd, input logic ordy);
        bus.a_valid = av;
        bus.a_data = ad;
        bus.b_valid = bv;
        bus.b_data = bd;
        bus.out_ready = ordy;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic s);
        chk({tag, "_valid"}, {7'b0, bus.out_valid}, {7'b0, v});
        chk({tag, "_data"}, bus.out_data, d);
        chk({tag, "_src"}, {7'b0, bus.out_src}, {7'b0, s});
    endtask
    task automatic chk_rdy(input string tag, input logic ar, input logic br);
        chk({tag, "_a_ready"}, {7'b0, bus.a_ready}, {7'b0, ar});
        chk({tag, "_b_ready"}, {7'b0, bus.b_ready}, {7'b0, br});
    endtask
    initial begin
        logic [7:0] ia, ib;
        rst_n = 1'b1;
        drv(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk_out("rst_async", 1'b0, 8'h00, 1'b0);
        chk_rdy("rst_async", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drv(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
            tick();
            chk_out("rst_hold", 1'b0, 8'h00, 1'b0);
            chk_rdy("rst_hold", 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        drv(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
        #1 chk_rdy("first_tie", 1'b1, 1'b0);
        tick();
        chk_out("first_tie", 1'b1, 8'h11, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            drv(1'b1, 8'(i), 1'b0, 8'h00, 1'b1);
            #1 chk_rdy("a_stream", 1'b1, 1'b0);
            tick();
            chk_out("a_stream", 1'b1, 8'(i), 1'b0);
        end
        drv(1'b0, 8'h00, 1'b1, 8'h10, 1'b1);
        #1 chk_rdy("b_only", 1'b0, 1'b1);
        tick();
        chk_out("b_only", 1'b1, 8'h10, 1'b1);
        drv(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 2; i++) begin
            #1 chk_rdy("gap", 1'b0, 1'b0);
            tick();
            chk_out("gap", 1'b0, 8'h10, 1'b1);
        end
        ia = 8'hA0;
        ib = 8'hB0;
        for (int k = 0; k < 6; k++) begin
            drv(1'b1, ia, 1'b1, ib, 1'b1);
            #1 chk_rdy("both", (k % 2) == 0, (k % 2) == 1);
            tick();
            if (k % 2 == 0) begin
                chk_out("both", 1'b1, ia, 1'b0);
                ia++;
            end else begin
                chk_out("both", 1'b1, ib, 1'b1);
                ib++;
            end
        end
        drv(1'b1, 8'h55, 1'b0, 8'h00, 1'b1);
        tick();
        chk_out("bp_load", 1'b1, 8'h55, 1'b0);
        drv(1'b1, 8'h66, 1'b1, 8'h77, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 chk_rdy("bp_hold", 1'b0, 1'b0);
            tick();
            chk_out("bp_hold", 1'b1, 8'h55, 1'b0);
        end
        bus.out_ready = 1'b1;
        #1 chk_rdy("bp_release", 1'b0, 1'b1);
        tick();
        chk_out("bp_release", 1'b1, 8'h77, 1'b1);
        drv(1'b1, 8'h66, 1'b0, 8'h00, 1'b1);
        tick();
        chk_out("bp_next", 1'b1, 8'h66, 1'b0);
        drv(1'b1, 8'hC1, 1'b1, 8'hC2, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk_out("mid_rst", 1'b0, 8'h00, 1'b0);
        chk_rdy("mid_rst", 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1 chk_rdy("post_rst_tie", 1'b1, 1'b0);
        tick();
        chk_out("post_rst_tie", 1'b1, 8'hC1, 1'b0);
        drv(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        tick();
        chk_out("drain", 1'b0, 8'hC1, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
